// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters the two
// encoder phases, decodes each Gray-code step into an enable pulse plus a
// direction for the downstream up/down counter, and flags and counts
// illegal double-edge transitions.

package counter_pkg;
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } count_dir_e;
endpackage

// One encoder phase: metastability chain followed by a persistence filter.
// The filter holds until told to load, so the decoder can seed it with the
// encoder's resting level once the synchroniser has flushed.
module quad_phase_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic load,
    input  logic run,
    output logic synced,
    output logic filtered
);
    localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   filt_r;
    logic [CNT_W-1:0]       cnt_r;

    // Shift the asynchronous phase through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_r[SYNC_STAGES-1];

    // Adopt a new level only after it has differed from the filtered value
    // for FILTER_LEN consecutive cycles; any return discards the pending change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            filt_r <= synced;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (!run) begin
            filt_r <= filt_r;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (synced == filt_r) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            filt_r <= synced;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign filtered = filt_r;
endmodule

// Invariants of the decoder outputs, kept apart from the datapath.
module quad_decoder_checker
    import counter_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 en,
    input count_dir_e           dir,
    input logic                 ready,
    input logic                 err,
    input logic [ERR_CNT_W-1:0] err_cnt
);
    // A step can only be reported once decoding is active.
    a_en_needs_ready : assert property (@(posedge clk) disable iff (rst) en |-> ready);

    // A non-zero error count always comes with the sticky flag.
    a_cnt_implies_flag : assert property (@(posedge clk) disable iff (rst)
        (err_cnt != {ERR_CNT_W{1'b0}}) |-> err);

    // Once active, decoding stays active until the next reset.
    a_ready_sticky : assert property (@(posedge clk) disable iff (rst) ready |=> ready);

    // Direction only moves together with a step pulse.
    a_dir_with_en : assert property (@(posedge clk) disable iff (rst) $changed(dir) |-> en);
endmodule

module quad_decoder
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_i,
    input  logic                 b_i,
    input  logic                 clr_err_i,
    output logic                 en_o,
    output count_dir_e           dir_o,
    output logic                 ready_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    localparam int              INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e               state_r;
    state_e               state_next_s;
    logic [INIT_W-1:0]    init_cnt_r;
    logic                 load_s;
    logic                 track_s;

    logic                 sa_s;
    logic                 sb_s;
    logic                 fa_s;
    logic                 fb_s;
    logic [1:0]           prev_r;

    logic                 step_up_s;
    logic                 step_dn_s;
    logic                 illegal_s;

    logic                 en_r;
    count_dir_e           dir_r;
    logic                 ready_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    quad_phase_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_a (
        .clk      (clk_i),
        .rst      (rst_i),
        .raw      (a_i),
        .load     (load_s),
        .run      (track_s),
        .synced   (sa_s),
        .filtered (fa_s)
    );

    quad_phase_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_b (
        .clk      (clk_i),
        .rst      (rst_i),
        .raw      (b_i),
        .load     (load_s),
        .run      (track_s),
        .synced   (sb_s),
        .filtered (fb_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Leave INIT once the synchroniser has flushed, seeding filters and history.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        track_s      = 1'b0;
        case (state_r)
            INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    load_s       = 1'b1;
                    state_next_s = TRACK;
                end else begin
                    state_next_s = INIT;
                end
            end
            TRACK: begin
                track_s      = 1'b1;
                state_next_s = TRACK;
            end
            default: begin
                state_next_s = INIT;
            end
        endcase
    end

    // Count edges since reset release while waiting for valid synchronised data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_cnt_r <= {INIT_W{1'b0}};
        end else if ((state_r == INIT) && !load_s) begin
            init_cnt_r <= init_cnt_r + INIT_W'(1);
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Remember last cycle's filtered code so each change is seen exactly once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_r <= 2'b00;
        end else if (load_s) begin
            prev_r <= {sa_s, sb_s};
        end else if (track_s) begin
            prev_r <= {fa_s, fb_s};
        end else begin
            prev_r <= prev_r;
        end
    end

    // Classify the old->new code pair: forward, reverse, illegal or no change.
    always_comb begin
        step_up_s = 1'b0;
        step_dn_s = 1'b0;
        illegal_s = 1'b0;
        if (track_s) begin
            case ({prev_r, fa_s, fb_s})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up_s = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn_s = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal_s = 1'b1;
                default: begin
                    step_up_s = 1'b0;
                    step_dn_s = 1'b0;
                    illegal_s = 1'b0;
                end
            endcase
        end else begin
            step_up_s = 1'b0;
            step_dn_s = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Step pulse and direction, updated together so the counter sees a consistent pair.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_r  <= 1'b0;
            dir_r <= UP;
        end else if (step_up_s) begin
            en_r  <= 1'b1;
            dir_r <= UP;
        end else if (step_dn_s) begin
            en_r  <= 1'b1;
            dir_r <= DOWN;
        end else begin
            en_r  <= 1'b0;
            dir_r <= dir_r;
        end
    end

    // Ready goes high when tracking starts and holds until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_r <= 1'b0;
        end else if (load_s) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= ready_r;
        end
    end

    // Sticky error flag and saturating count; a clear wins over a same-cycle event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (clr_err_i) begin
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (illegal_s) begin
            err_r     <= 1'b1;
            if (err_cnt_r != ERR_MAX) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            err_r     <= err_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign en_o      = en_r;
    assign dir_o     = dir_r;
    assign ready_o   = ready_r;
    assign err_o     = err_r;
    assign err_cnt_o = err_cnt_r;

    quad_decoder_checker #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_checker (
        .clk     (clk_i),
        .rst     (rst_i),
        .en      (en_r),
        .dir     (dir_r),
        .ready   (ready_r),
        .err     (err_r),
        .err_cnt (err_cnt_r)
    );
endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios followed by random phase
// activity, all checked every cycle against a window-based reference model.
module tb_quad_decoder;
    import counter_pkg::*;

    localparam int S  = 2;
    localparam int F  = 4;
    localparam int EW = 2;

    logic          clk_i     = 1'b0;
    logic          rst_i     = 1'b0;
    logic          a_i       = 1'b0;
    logic          b_i       = 1'b0;
    logic          clr_err_i = 1'b0;
    logic          en_o;
    count_dir_e    dir_o;
    logic          ready_o;
    logic          err_o;
    logic [EW-1:0] err_cnt_o;

    quad_decoder #(
        .SYNC_STAGES (S),
        .FILTER_LEN  (F),
        .ERR_CNT_W   (EW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .clr_err_i (clr_err_i),
        .en_o      (en_o),
        .dir_o     (dir_o),
        .ready_o   (ready_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: raw samples per edge since reset release, filtered
    // and previous codes, expected outputs, and a downstream counter.
    bit         ha [8192];
    bit         hb [8192];
    int         n;
    bit         mf_a, mf_b, mp_a, mp_b;
    bit         m_en, m_dir, m_ready, m_err;
    int         m_cnt;
    logic [7:0] m_pos   = 8'd0;
    logic [7:0] obs_pos = 8'd0;
    int         gp [4]  = '{0, 3, 1, 2};   // Gray position of code {a,b}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_outputs();
        check("en_o",      32'(en_o),      32'(m_en));
        check("dir_o",     32'(dir_o),     32'(m_dir));
        check("ready_o",   32'(ready_o),   32'(m_ready));
        check("err_o",     32'(err_o),     32'(m_err));
        check("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
    endtask

    function automatic bit all_differ(input int lo, input int hi, input bit use_b, input bit fv);
        for (int i = lo; i <= hi; i++) begin
            if ((use_b ? hb[i] : ha[i]) == fv) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        n = 0; mf_a = 0; mf_b = 0; mp_a = 0; mp_b = 0;
        m_en = 0; m_dir = 0; m_ready = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit na, input bit nb, input bit clr);
        int d;
        bit ill;
        bit nfa, nfb;
        n++;
        ha[n] = na;
        hb[n] = nb;
        m_en  = 0;
        ill   = 0;
        if (n == S + 1) begin
            mf_a = ha[1]; mf_b = hb[1]; mp_a = mf_a; mp_b = mf_b;
            m_ready = 1;
        end else if (n > S + 1) begin
            d = (gp[{mf_a, mf_b}] - gp[{mp_a, mp_b}] + 4) % 4;
            if (d == 1) begin m_en = 1; m_dir = 0; end
            else if (d == 3) begin m_en = 1; m_dir = 1; end
            else if (d == 2) ill = 1;
            mp_a = mf_a; mp_b = mf_b;
            if (n >= S + F + 1) begin
                nfa = all_differ(n - S - F + 1, n - S, 1'b0, mf_a) ? !mf_a : mf_a;
                nfb = all_differ(n - S - F + 1, n - S, 1'b1, mf_b) ? !mf_b : mf_b;
                mf_a = nfa; mf_b = nfb;
            end
        end
        if (clr) begin
            m_err = 0; m_cnt = 0;
        end else if (ill) begin
            m_err = 1;
            if (m_cnt < (1 << EW) - 1) m_cnt++;
        end
        if (m_en) m_pos = m_dir ? m_pos - 8'd1 : m_pos + 8'd1;
    endtask

    task automatic tick(input bit na, input bit nb, input bit clr);
        a_i = na; b_i = nb; clr_err_i = clr;
        @(posedge clk_i);
        model_edge(na, nb, clr);
        #1;
        check_outputs();
        if (en_o === 1'b1) obs_pos = (dir_o == DOWN) ? obs_pos - 8'd1 : obs_pos + 8'd1;
    endtask

    task automatic hold(input bit na, input bit nb, input int cycles);
        for (int i = 0; i < cycles; i++) tick(na, nb, 1'b0);
    endtask

    // Asynchronous reset: outputs must be at reset values immediately.
    task automatic do_reset(input bit ra, input bit rb);
        rst_i = 1'b1; a_i = ra; b_i = rb; clr_err_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    logic [7:0] base;
    bit         ca, cb, na, nb;
    int         r, len;

    initial begin
        a_i = 1'b1; b_i = 1'b1;
        #1;
        // Encoder resting at 11 through reset and init.
        do_reset(1'b1, 1'b1);
        hold(1'b1, 1'b1, 12);
        // 11 -> 01 -> 00 are forward steps.
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);

        // Forward sequence.
        base = obs_pos;
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        check("fwd_steps", 32'(obs_pos - base), 32'd4);
        check("fwd_dir", 32'(dir_o), 32'(UP));

        // Reverse sequence from a zeroed counter wraps to 251.
        obs_pos = 8'd0; m_pos = 8'd0;
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 10);
        hold(1'b0, 1'b1, 10);
        check("rev_count", 32'(obs_pos), 32'd251);
        check("rev_dir", 32'(dir_o), 32'(DOWN));
        hold(1'b0, 1'b0, 10);

        // Glitch filter: 3-cycle pulse rejected, 4-cycle level accepted.
        base = obs_pos;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 12);
        check("glitch3_steps", 32'(obs_pos - base), 32'd0);
        check("glitch3_err", 32'(err_o), 32'd0);
        hold(1'b1, 1'b0, 4);
        hold(1'b1, 1'b0, 10);
        check("glitch4_steps", 32'(obs_pos - base), 32'd1);
        check("glitch4_dir", 32'(dir_o), 32'(UP));

        // Five illegal double toggles saturate the 2-bit count.
        base = obs_pos;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) hold(1'b0, 1'b1, 10);
            else            hold(1'b1, 1'b0, 10);
        end
        check("illegal_steps", 32'(obs_pos - base), 32'd0);
        check("err_flag", 32'(err_o), 32'd1);
        check("err_sat", 32'(err_cnt_o), 32'd3);
        // Sixth toggle with the clear on the very edge that would record it.
        for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0, k == S + F + 1);
        check("clr_err_flag", 32'(err_o), 32'd0);
        check("clr_err_cnt", 32'(err_cnt_o), 32'd0);

        // Reset during a pending filter count.
        hold(1'b1, 1'b1, 3);
        #1;
        do_reset(1'b1, 1'b1);
        hold(1'b1, 1'b1, 12);
        // Reset while a step pulse is high.
        hold(1'b0, 1'b1, S + F + 1);
        check("pulse_before_rst", 32'(en_o), 32'd1);
        #1;
        do_reset(1'b0, 1'b1);
        hold(1'b0, 1'b1, 12);
        hold(1'b0, 1'b0, 10);

        // Random phase activity including glitches, illegal moves and clears.
        ca = 1'b0; cb = 1'b0;
        for (int it = 0; it < 150; it++) begin
            r  = int'($urandom_range(0, 9));
            na = ca; nb = cb;
            if (r <= 5) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (ca == cb) na = !ca; else nb = !cb;   // forward
                end else begin
                    if (ca == cb) nb = !cb; else na = !ca;   // reverse
                end
            end else if (r == 6) begin
                na = !ca; nb = !cb;
            end else if (r <= 8) begin
                len = int'($urandom_range(1, F + 1));
                for (int j = 0; j < len; j++) tick(!ca, cb, $urandom_range(0, 15) == 0);
            end else begin
                na = 1'($urandom_range(0, 1)); nb = 1'($urandom_range(0, 1));
            end
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) tick(na, nb, $urandom_range(0, 15) == 0);
            ca = na; cb = nb;
        end
        hold(ca, cb, 12);
        check("final_count", 32'(obs_pos), 32'(m_pos));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
